// File: rtl/hangman_word_if.sv
// Hangman word datapath bus.
// Groups the control strobes and character inputs from the game FSM, the
// guess-result feedback returned to it, and the display read port used by
// the VGA renderer.
//   master : game FSM / renderer side (drives strobes, chars, rd_idx)
//   slave  : word datapath side (drives status, results, rd_char/rd_revealed)
interface hangman_word_if #(
  parameter int MAX_LEN = 16,
  parameter int CHAR_W  = 5
);
  localparam int IDX_W = $clog2(MAX_LEN);
  localparam int CNT_W = $clog2(MAX_LEN + 1);

  logic              clear;
  logic              ld;
  logic              char_valid;
  logic [CHAR_W-1:0] char_in;
  logic              compare;
  logic [CHAR_W-1:0] guess;
  logic              busy;
  logic              done;
  logic              match;
  logic              miss;
  logic              repeat_guess;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  wordcount;
  logic [CNT_W-1:0]  remain;
  logic              all_revealed;
  logic              overflow;
  logic [IDX_W-1:0]  rd_idx;
  logic [CHAR_W-1:0] rd_char;
  logic              rd_revealed;

  modport master (
    output clear, ld, char_valid, char_in, compare, guess, rd_idx,
    input  busy, done, match, miss, repeat_guess, count, wordcount, remain,
           all_revealed, overflow, rd_char, rd_revealed
  );

  modport slave (
    input  clear, ld, char_valid, char_in, compare, guess, rd_idx,
    output busy, done, match, miss, repeat_guess, count, wordcount, remain,
           all_revealed, overflow, rd_char, rd_revealed
  );
endinterface

// File: rtl/hangman_word_datapath.sv
// Hangman word storage and guess-comparison datapath.
// Stores the secret word plus a per-position revealed mask, scans each guess
// one position per clock, and reports match/miss/repeat/count feedback.
// Ports:
//   clk    : clock
//   resetn : asynchronous active-low reset
//   bus    : hangman_word_if slave (clear/ld/char/compare in, results out,
//            combinational display read port rd_idx -> rd_char/rd_revealed)
//
// state  | meaning
// IDLE   | accepting loads and compare strobes
// SCAN   | checking word[idx] against latched guess, one position per clock
// REPORT | one-cycle done; publish results, update remain and history
module hangman_word_datapath #(
  parameter int MAX_LEN = 16,
  parameter int CHAR_W  = 5
) (
  input logic          clk,
  input logic          resetn,
  hangman_word_if.slave bus
);
  localparam int IDX_W  = $clog2(MAX_LEN);
  localparam int CNT_W  = $clog2(MAX_LEN + 1);
  localparam int HIST_W = 2 ** CHAR_W;

  typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_t;

  state_t                      state_q, state_d;
  logic [CHAR_W-1:0]           word_q [MAX_LEN];
  logic [CHAR_W-1:0]           word_d [MAX_LEN];
  logic [MAX_LEN-1:0]          revealed_q, revealed_d;
  logic [HIST_W-1:0]           hist_q, hist_d;
  logic [CNT_W-1:0]            wordcount_q, wordcount_d;
  logic [CNT_W-1:0]            remain_q, remain_d;
  logic [CNT_W-1:0]            acc_q, acc_d;
  logic [CNT_W-1:0]            count_q, count_d;
  logic [CHAR_W-1:0]           g_q, g_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic                        match_q, match_d;
  logic                        miss_q, miss_d;
  logic                        repeat_q, repeat_d;
  logic                        overflow_q, overflow_d;
  logic                        rep_w;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      word_q      <= '{default: '0};
      revealed_q  <= '0;
      hist_q      <= '0;
      wordcount_q <= '0;
      remain_q    <= '0;
      acc_q       <= '0;
      count_q     <= '0;
      g_q         <= '0;
      idx_q       <= '0;
      match_q     <= 1'b0;
      miss_q      <= 1'b0;
      repeat_q    <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      revealed_q  <= revealed_d;
      hist_q      <= hist_d;
      wordcount_q <= wordcount_d;
      remain_q    <= remain_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      g_q         <= g_d;
      idx_q       <= idx_d;
      match_q     <= match_d;
      miss_q      <= miss_d;
      repeat_q    <= repeat_d;
      overflow_q  <= overflow_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    revealed_d  = revealed_q;
    hist_d      = hist_q;
    wordcount_d = wordcount_q;
    remain_d    = remain_q;
    acc_d       = acc_q;
    count_d     = count_q;
    g_d         = g_q;
    idx_d       = idx_q;
    match_d     = match_q;
    miss_d      = miss_q;
    repeat_d    = repeat_q;
    overflow_d  = overflow_q;
    rep_w       = (g_q != '0) && hist_q[g_q];

    if (bus.clear) begin
      // New game: identical to reset, and aborts any scan without a done.
      state_d     = IDLE;
      word_d      = '{default: '0};
      revealed_d  = '0;
      hist_d      = '0;
      wordcount_d = '0;
      remain_d    = '0;
      acc_d       = '0;
      count_d     = '0;
      g_d         = '0;
      idx_d       = '0;
      match_d     = 1'b0;
      miss_d      = 1'b0;
      repeat_d    = 1'b0;
      overflow_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // compare wins over a simultaneous load; that load is dropped.
          if (bus.compare) begin
            g_d     = bus.guess;
            idx_d   = '0;
            acc_d   = '0;
            state_d = (wordcount_q == '0) ? REPORT : SCAN;
          end else if (bus.ld && bus.char_valid && bus.char_in != '0) begin
            if (wordcount_q < CNT_W'(MAX_LEN)) begin
              word_d[wordcount_q[IDX_W-1:0]]     = bus.char_in;
              revealed_d[wordcount_q[IDX_W-1:0]] = 1'b0;
              wordcount_d = wordcount_q + CNT_W'(1);
              remain_d    = remain_q + CNT_W'(1);
            end else begin
              overflow_d = 1'b1;
            end
          end
        end
        SCAN: begin
          // Only unrevealed positions count, so remain can never underflow.
          if (g_q != '0 && word_q[idx_q] == g_q && !revealed_q[idx_q]) begin
            revealed_d[idx_q] = 1'b1;
            acc_d             = acc_q + CNT_W'(1);
          end
          if (CNT_W'(idx_q) == wordcount_q - CNT_W'(1)) begin
            state_d = REPORT;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
        REPORT: begin
          count_d  = acc_q;
          remain_d = remain_q - acc_q;
          repeat_d = rep_w;
          match_d  = (acc_q != '0);
          miss_d   = (acc_q == '0) && !rep_w;
          if (g_q != '0) begin
            hist_d[g_q] = 1'b1;
          end
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.busy         = (state_q != IDLE);
  assign bus.done         = (state_q == REPORT);
  assign bus.match        = match_q;
  assign bus.miss         = miss_q;
  assign bus.repeat_guess = repeat_q;
  assign bus.count        = count_q;
  assign bus.wordcount    = wordcount_q;
  assign bus.remain       = remain_q;
  assign bus.all_revealed = (wordcount_q != '0) && (remain_q == '0);
  assign bus.overflow     = overflow_q;

  // Positions at or beyond wordcount read as blank and hidden.
  always_comb begin
    bus.rd_char     = '0;
    bus.rd_revealed = 1'b0;
    if (CNT_W'(bus.rd_idx) < wordcount_q) begin
      bus.rd_char     = word_q[bus.rd_idx];
      bus.rd_revealed = revealed_q[bus.rd_idx];
    end
  end
endmodule

// File: tb/tb_hangman_word_datapath.sv
module tb_hangman_word_datapath;
  logic clk;
  logic resetn;
  int   checks;
  int   errors;

  hangman_word_if #(.MAX_LEN(16), .CHAR_W(5)) bus ();

  hangman_word_datapath #(.MAX_LEN(16), .CHAR_W(5)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_char(input logic [4:0] c);
    bus.ld         = 1'b1;
    bus.char_valid = 1'b1;
    bus.char_in    = c;
    tick();
    bus.ld         = 1'b0;
    bus.char_valid = 1'b0;
    bus.char_in    = '0;
  endtask

  // Pulses compare, measures cycles until done and busy cycles, then steps
  // past REPORT so the published results can be checked by the caller.
  task automatic run_guess(input logic [4:0] g, input int n_exp, input string nm);
    int k;
    int busy_n;
    bus.compare = 1'b1;
    bus.guess   = g;
    tick();
    bus.compare = 1'b0;
    k = 0;
    busy_n = 0;
    while (bus.done !== 1'b1 && k < 40) begin
      if (bus.busy === 1'b1) busy_n++;
      tick();
      k++;
    end
    checks++;
    if (k !== n_exp) begin
      errors++;
      $display("FAIL %s latency: got %0d want %0d", nm, k, n_exp);
    end
    checks++;
    if (busy_n !== n_exp) begin
      errors++;
      $display("FAIL %s busy cycles before done: got %0d want %0d", nm, busy_n, n_exp);
    end
    tick();
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL %s idle after report: got done=%b busy=%b want 0 0", nm, bus.done, bus.busy);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    #3;
    checks++;
    if ({bus.busy, bus.done, bus.match, bus.miss, bus.repeat_guess, bus.count,
         bus.wordcount, bus.remain, bus.all_revealed, bus.overflow,
         bus.rd_char, bus.rd_revealed} !== '0) begin
      errors++;
      $display("FAIL reset outputs: got busy=%b done=%b wc=%0d remain=%0d ovf=%b want all 0",
               bus.busy, bus.done, bus.wordcount, bus.remain, bus.overflow);
    end
    @(negedge clk);
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_load();
    load_char(5'd1);
    // ignored: ld low, and zero character
    bus.char_valid = 1'b1; bus.char_in = 5'd9; tick();
    bus.char_valid = 1'b0; bus.char_in = '0;
    load_char(5'd0);
    load_char(5'd2);
    load_char(5'd2);
    load_char(5'd1);
    checks++;
    if (bus.wordcount !== 5'd4 || bus.remain !== 5'd4) begin
      errors++;
      $display("FAIL load counts: got wc=%0d remain=%0d want 4 4", bus.wordcount, bus.remain);
    end
    bus.rd_idx = 4'd2; #1;
    checks++;
    if (bus.rd_char !== 5'd2 || bus.rd_revealed !== 1'b0) begin
      errors++;
      $display("FAIL rd_char[2]: got %0d rev=%b want 2 0", bus.rd_char, bus.rd_revealed);
    end
    bus.rd_idx = 4'd5; #1;
    checks++;
    if (bus.rd_char !== 5'd0) begin
      errors++;
      $display("FAIL rd_char past end: got %0d want 0", bus.rd_char);
    end
  endtask

  task automatic test_match();
    run_guess(5'd2, 4, "guess_B");
    checks++;
    if (bus.match !== 1'b1 || bus.miss !== 1'b0 || bus.repeat_guess !== 1'b0 ||
        bus.count !== 5'd2 || bus.remain !== 5'd2) begin
      errors++;
      $display("FAIL guess_B result: got m=%b mi=%b r=%b cnt=%0d rem=%0d want 1 0 0 2 2",
               bus.match, bus.miss, bus.repeat_guess, bus.count, bus.remain);
    end
    bus.rd_idx = 4'd1; #1;
    checks++;
    if (bus.rd_revealed !== 1'b1) begin
      errors++;
      $display("FAIL rd_revealed[1]: got %b want 1", bus.rd_revealed);
    end
    bus.rd_idx = 4'd2; #1;
    checks++;
    if (bus.rd_revealed !== 1'b1) begin
      errors++;
      $display("FAIL rd_revealed[2]: got %b want 1", bus.rd_revealed);
    end
    bus.rd_idx = 4'd0; #1;
    checks++;
    if (bus.rd_revealed !== 1'b0) begin
      errors++;
      $display("FAIL rd_revealed[0]: got %b want 0", bus.rd_revealed);
    end
  endtask

  task automatic test_repeat_and_miss();
    run_guess(5'd2, 4, "repeat_B");
    checks++;
    if (bus.repeat_guess !== 1'b1 || bus.match !== 1'b0 || bus.miss !== 1'b0 ||
        bus.count !== 5'd0 || bus.remain !== 5'd2) begin
      errors++;
      $display("FAIL repeat_B result: got r=%b m=%b mi=%b cnt=%0d rem=%0d want 1 0 0 0 2",
               bus.repeat_guess, bus.match, bus.miss, bus.count, bus.remain);
    end
    run_guess(5'd26, 4, "guess_Z");
    checks++;
    if (bus.miss !== 1'b1 || bus.match !== 1'b0 || bus.repeat_guess !== 1'b0 ||
        bus.count !== 5'd0 || bus.remain !== 5'd2) begin
      errors++;
      $display("FAIL guess_Z result: got mi=%b m=%b r=%b cnt=%0d rem=%0d want 1 0 0 0 2",
               bus.miss, bus.match, bus.repeat_guess, bus.count, bus.remain);
    end
  endtask

  task automatic test_busy_ignore();
    int dones;
    bus.compare = 1'b1; bus.guess = 5'd1; tick();
    bus.compare = 1'b0;
    tick();
    // extra compare mid-scan must be dropped
    bus.compare = 1'b1; bus.guess = 5'd26; tick();
    bus.compare = 1'b0; bus.guess = '0;
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.done === 1'b1) dones++;
      tick();
    end
    checks++;
    if (dones !== 1) begin
      errors++;
      $display("FAIL busy_ignore done pulses: got %0d want 1", dones);
    end
    checks++;
    if (bus.count !== 5'd2 || bus.remain !== 5'd0 || bus.all_revealed !== 1'b1 ||
        bus.match !== 1'b1) begin
      errors++;
      $display("FAIL guess_A result: got cnt=%0d rem=%0d all=%b m=%b want 2 0 1 1",
               bus.count, bus.remain, bus.all_revealed, bus.match);
    end
  endtask

  task automatic test_overflow_empty();
    bus.clear = 1'b1; tick(); bus.clear = 1'b0;
    for (int i = 0; i < 17; i++) load_char(5'(i + 1));
    checks++;
    if (bus.wordcount !== 5'd16 || bus.overflow !== 1'b1 || bus.remain !== 5'd16) begin
      errors++;
      $display("FAIL overflow: got wc=%0d ovf=%b rem=%0d want 16 1 16",
               bus.wordcount, bus.overflow, bus.remain);
    end
    bus.rd_idx = 4'd15; #1;
    checks++;
    if (bus.rd_char !== 5'd16) begin
      errors++;
      $display("FAIL rd_char[15]: got %0d want 16", bus.rd_char);
    end
    bus.clear = 1'b1; tick(); bus.clear = 1'b0;
    checks++;
    if (bus.wordcount !== 5'd0 || bus.overflow !== 1'b0 || bus.all_revealed !== 1'b0) begin
      errors++;
      $display("FAIL clear state: got wc=%0d ovf=%b all=%b want 0 0 0",
               bus.wordcount, bus.overflow, bus.all_revealed);
    end
    run_guess(5'd3, 0, "empty_word");
    checks++;
    if (bus.miss !== 1'b1 || bus.count !== 5'd0 || bus.match !== 1'b0) begin
      errors++;
      $display("FAIL empty_word result: got mi=%b cnt=%0d m=%b want 1 0 0",
               bus.miss, bus.count, bus.match);
    end
    run_guess(5'd0, 0, "guess_zero");
    checks++;
    if (bus.miss !== 1'b1 || bus.repeat_guess !== 1'b0) begin
      errors++;
      $display("FAIL guess_zero result: got mi=%b r=%b want 1 0", bus.miss, bus.repeat_guess);
    end
  endtask

  // use_reset=0 aborts with clear, 1 aborts with async resetn.
  task automatic test_abort(input bit use_reset, input string nm);
    int dones;
    bus.clear = 1'b1; tick(); bus.clear = 1'b0;
    load_char(5'd3); load_char(5'd1); load_char(5'd20);
    run_guess(5'd20, 3, {nm, "_T"});
    checks++;
    if (bus.count !== 5'd1 || bus.remain !== 5'd2) begin
      errors++;
      $display("FAIL %s_T result: got cnt=%0d rem=%0d want 1 2", nm, bus.count, bus.remain);
    end
    bus.compare = 1'b1; bus.guess = 5'd1; tick();
    bus.compare = 1'b0;
    tick(); tick();
    // scan now at idx 2, REPORT not yet entered
    if (use_reset) begin
      #2 resetn = 1'b0;
      #3 resetn = 1'b1;
    end else begin
      bus.clear = 1'b1; tick(); bus.clear = 1'b0;
    end
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.done === 1'b1) dones++;
      tick();
    end
    checks++;
    if (dones !== 0 || bus.busy !== 1'b0 || bus.wordcount !== 5'd0 || bus.remain !== 5'd0 ||
        bus.count !== 5'd0) begin
      errors++;
      $display("FAIL %s abort: got dones=%0d busy=%b wc=%0d rem=%0d cnt=%0d want 0 0 0 0 0",
               nm, dones, bus.busy, bus.wordcount, bus.remain, bus.count);
    end
    load_char(5'd4); load_char(5'd15); load_char(5'd7);
    run_guess(5'd20, 3, {nm, "_hist"});
    checks++;
    if (bus.miss !== 1'b1 || bus.repeat_guess !== 1'b0) begin
      errors++;
      $display("FAIL %s history cleared: got mi=%b r=%b want 1 0", nm, bus.miss, bus.repeat_guess);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    bus.clear      = 1'b0;
    bus.ld         = 1'b0;
    bus.char_valid = 1'b0;
    bus.char_in    = '0;
    bus.compare    = 1'b0;
    bus.guess      = '0;
    bus.rd_idx     = '0;
    test_reset();
    test_load();
    test_match();
    test_repeat_and_miss();
    test_busy_ignore();
    test_overflow_empty();
    test_abort(1'b0, "clear");
    test_abort(1'b1, "resetn");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
